// File: rtl/week6_ex1_xor_frame_parity_if.sv
// Stream bundle for the frame parity unit: the beat input handshake and the frame result handshake.
// The slave modport is the parity unit; the master modport is the source/sink that surrounds it.
interface week6_ex1_xor_frame_parity_if #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             odd_mode;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_col_parity;
  logic             out_parity;
  logic [LW-1:0]    out_len;
  logic             out_overflow;

  modport master (
    output in_valid, in_data, in_last, odd_mode, out_ready,
    input  in_ready, out_valid, out_col_parity, out_parity, out_len, out_overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, odd_mode, out_ready,
    output in_ready, out_valid, out_col_parity, out_parity, out_len, out_overflow
  );
endinterface

// File: rtl/week6_ex1_xor_frame_parity.sv
// Streaming column-parity unit: XORs every beat of a frame, then holds the frame result
// (column parity, scalar parity, saturated length, overflow) until downstream accepts it.
module week6_ex1_xor_frame_parity #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16
) (
  input logic clk,
  input logic rst_n,
  week6_ex1_xor_frame_parity_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [LW-1:0]    cnt;
  logic             ovf;
  logic             mode;

  logic [WIDTH-1:0] col_q;
  logic             par_q;
  logic [LW-1:0]    len_q;
  logic             ovf_q;

  logic             accept;
  logic [WIDTH-1:0] acc_nxt;
  logic [LW-1:0]    cnt_nxt;
  logic             ovf_nxt;
  logic             mode_nxt;

  assign accept = bus.in_valid && (state != HOLD);

  // Accumulator values as they stand once the current beat is folded in.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    acc_nxt  = acc;
    cnt_nxt  = cnt;
    ovf_nxt  = ovf;
    mode_nxt = mode;
    if (state == IDLE) begin
      acc_nxt  = bus.in_data;
      cnt_nxt  = LW'(1);
      ovf_nxt  = 1'b0;
      mode_nxt = bus.odd_mode;
    end else if (state == ACCUM) begin
      acc_nxt = acc ^ bus.in_data;
      if (cnt < LW'(MAX_LEN)) cnt_nxt = cnt + 1'b1;
      else                    ovf_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      mode  <= 1'b0;
      col_q <= '0;
      par_q <= 1'b0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        acc  <= acc_nxt;
        cnt  <= cnt_nxt;
        ovf  <= ovf_nxt;
        mode <= mode_nxt;
      end
      case (state)
        IDLE, ACCUM: begin
          if (accept && bus.in_last) begin
            state <= HOLD;
            col_q <= acc_nxt;
            par_q <= (^acc_nxt) ^ mode_nxt;
            len_q <= cnt_nxt;
            ovf_q <= ovf_nxt;
          end else if (accept) begin
            state <= ACCUM;
          end
        end
        HOLD: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready       = (state != HOLD);
  assign bus.out_valid      = (state == HOLD);
  assign bus.out_col_parity = col_q;
  assign bus.out_parity     = par_q;
  assign bus.out_len        = len_q;
  assign bus.out_overflow   = ovf_q;
endmodule

// File: tb/tb_week6_ex1_xor_frame_parity.sv
// Bench for the frame parity unit: frame vector table, hand-written corner sequences,
// and a random run against a frame-level reference model.
module tb_week6_ex1_xor_frame_parity;
  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 16;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  week6_ex1_xor_frame_parity_if #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) bus ();

  week6_ex1_xor_frame_parity #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: whole frames kept as a list of beats, result computed when the frame closes.
  bit         m_pending;
  logic [7:0] m_beats[$];
  bit         m_mode;
  logic [7:0] m_col;
  bit         m_par;
  int         m_len;
  bit         m_ovf;

  function automatic void model_reset();
    m_pending = 1'b0;
    m_beats.delete();
    m_mode = 1'b0;
    m_col  = 8'h00;
    m_par  = 1'b0;
    m_len  = 0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void model_edge(input bit v, input logic [7:0] d, input bit l,
                                     input bit m, input bit r);
    logic [7:0] x;
    x = 8'h00;
    if (m_pending) begin
      if (r) m_pending = 1'b0;
    end else if (v) begin
      if (m_beats.size() == 0) m_mode = m;
      m_beats.push_back(d);
      if (l) begin
        foreach (m_beats[i]) x = x ^ m_beats[i];
        m_col     = x;
        m_par     = (^x) ^ m_mode;
        m_len     = (m_beats.size() > MAX_LEN) ? MAX_LEN : m_beats.size();
        m_ovf     = (m_beats.size() > MAX_LEN);
        m_pending = 1'b1;
        m_beats.delete();
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("in_ready",       32'(bus.in_ready),       32'(!m_pending));
    check("out_valid",      32'(bus.out_valid),      32'(m_pending));
    check("out_col_parity", 32'(bus.out_col_parity), 32'(m_col));
    check("out_parity",     32'(bus.out_parity),     32'(m_par));
    check("out_len",        32'(bus.out_len),        32'(m_len));
    check("out_overflow",   32'(bus.out_overflow),   32'(m_ovf));
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input bit v, input logic [7:0] d, input bit l, input bit m, input bit r);
    rst_n        = 1'b1;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.odd_mode = m;
    bus.out_ready = r;
    model_edge(v, d, l, m, r);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic rst_cyc();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA5;
    bus.in_last   = 1'b1;
    bus.odd_mode  = 1'b1;
    bus.out_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  typedef struct {
    logic [7:0] data;
    bit         last;
    bit         mode;
    logic [7:0] col;
    bit         par;
    int         len;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lens[2];
    bit rv;
    bit rl;
    bit rr;
    int last_pct;

    vecs[0] = '{8'h0F, 1'b0, 1'b0, 8'h00, 1'b0, 0};
    vecs[1] = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 8'hC3, 1'b0, 3};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 0};
    vecs[6] = '{8'h01, 1'b1, 1'b1, 8'hFE, 1'b1, 2};
    vecs[7] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1};

    // Reset held two cycles with a valid last beat on the input: nothing may be taken.
    rst_cyc();
    rst_cyc();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_col",       32'(bus.out_col_parity), 32'd0);
    check("rst_len",       32'(bus.out_len),   32'd0);

    // Frame table; odd_mode on a non-first beat must not matter (vector 6).
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, vecs[i].data, vecs[i].last, vecs[i].mode, 1'b1);
      if (vecs[i].last) begin
        check("vec_out_valid", 32'(bus.out_valid),      32'd1);
        check("vec_col",       32'(bus.out_col_parity), 32'(vecs[i].col));
        check("vec_par",       32'(bus.out_parity),     32'(vecs[i].par));
        check("vec_len",       32'(bus.out_len),        32'(vecs[i].len));
        check("vec_ovf",       32'(bus.out_overflow),   32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("vec_release",   32'(bus.in_ready),       32'd1);
      end else begin
        check("vec_no_valid",  32'(bus.out_valid),      32'd0);
      end
    end

    // Back-pressure: result held for five cycles while beats are offered.
    cyc(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h34, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      check("bp_in_ready", 32'(bus.in_ready),       32'd0);
      check("bp_col",      32'(bus.out_col_parity), 32'h26);
      check("bp_len",      32'(bus.out_len),        32'd2);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h80, 1'b1, 1'b0, 1'b1);
    check("bp_next_col", 32'(bus.out_col_parity), 32'h80);
    check("bp_next_par", 32'(bus.out_parity),     32'd1);
    check("bp_next_len", 32'(bus.out_len),        32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Length boundary: MAX_LEN beats fit, MAX_LEN+1 overflows.
    lens[0] = MAX_LEN;
    lens[1] = MAX_LEN + 1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 1; i <= lens[k]; i++) cyc(1'b1, 8'hFF, (i == lens[k]), 1'b0, 1'b1);
      check("edge_len", 32'(bus.out_len),      32'(MAX_LEN));
      check("edge_ovf", 32'(bus.out_overflow), 32'(k));
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end

    // Overflow: 18 beats of 0xFF, then a single-beat frame clears the flag.
    for (int i = 1; i <= 18; i++) cyc(1'b1, 8'hFF, (i == 18), 1'b0, 1'b1);
    check("ovf_col", 32'(bus.out_col_parity), 32'h00);
    check("ovf_len", 32'(bus.out_len),        32'd16);
    check("ovf_flag", 32'(bus.out_overflow),  32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
    check("ovf_clear", 32'(bus.out_overflow), 32'd0);
    check("ovf_clear_len", 32'(bus.out_len),  32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame discards the partial frame.
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    rst_cyc();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    check("mid_rst_col", 32'(bus.out_col_parity), 32'h55);
    check("mid_rst_len", 32'(bus.out_len),        32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Random traffic: alternating short-frame and long-frame phases, occasional reset.
    for (int n = 0; n < 3000; n++) begin
      last_pct = ((n / 500) % 2 == 0) ? 30 : 3;
      rv = ($urandom_range(0, 99) < 75);
      rl = ($urandom_range(0, 99) < last_pct);
      rr = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 299) == 0) rst_cyc();
      else cyc(rv, 8'($urandom), rl, 1'($urandom), rr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
